// File: rtl/otter_alu_pkg.sv
// Shared types for the OTTER execute unit: base ALU codes, RV32M funct3 codes
// and the iterative mul/div sequencer states.
package otter_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        FIXUP = 2'd3
    } md_state_e;

    // Operand A is treated as two's complement for these ops
    function automatic logic md_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Operand B is treated as two's complement for these ops
    function automatic logic md_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/otter_md_core.sv
// Iterative RV32M engine: sign preparation, shift-add multiplier, restoring
// divider, sequencing FSM and iteration counter. start/done handshake.
module otter_md_core
    import otter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          r_state;
    md_op_e             r_op;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WIDTH-1:0]   r_x, r_y, r_rem;
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic               r_neg_res, r_neg_rem, r_div0, r_ovf;

    logic               w_sa, w_sb, w_ge;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_sub, w_quo, w_remv;
    logic [WIDTH:0]     w_shift;
    logic [2*WIDTH-1:0] w_acc_next, w_prod;

    // Operand magnitudes for the signed variants
    always_comb begin
        w_sa    = md_a_signed(r_op) & r_a[WIDTH-1];
        w_sb    = md_b_signed(r_op) & r_b[WIDTH-1];
        w_mag_a = w_sa ? -r_a : r_a;
        w_mag_b = w_sb ? -r_b : r_b;
    end

    // One multiplier step and one restoring-division step
    always_comb begin
        w_acc_next = r_y[0] ? (r_acc + r_mcand) : r_acc;
        w_shift    = {r_rem, r_x[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_y});
        w_sub      = w_shift[WIDTH-1:0] - r_y;
    end

    // Apply signs, pick the requested half/quantity and the special-case overrides
    always_comb begin
        w_prod   = r_neg_res ? -r_acc : r_acc;
        w_quo    = r_neg_res ? -r_x : r_x;
        w_remv   = r_neg_rem ? -r_rem : r_rem;
        o_result = '0;
        case (r_op)
            MD_MUL:                       o_result = w_prod[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              o_result = r_div0 ? '1 : (r_ovf ? MIN_VAL : w_quo);
            MD_REM, MD_REMU:              o_result = r_div0 ? r_a : (r_ovf ? '0 : w_remv);
            default:                      o_result = '0;
        endcase
        o_busy = (r_state != IDLE);
        o_done = (r_state == FIXUP);
    end

    // Sequencer: latch on start, prepare, iterate WIDTH times, finish in FIXUP
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_op      <= MD_MUL;
            r_count   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_rem     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op    <= md_op_e'(i_funct3);
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    r_div0    <= (r_b == '0);
                    r_ovf     <= (r_a == MIN_VAL) && (r_b == '1) &&
                                 ((r_op == MD_DIV) || (r_op == MD_REM));
                    r_acc     <= '0;
                    r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                    r_x       <= w_mag_a;
                    r_y       <= w_mag_b;
                    r_rem     <= '0;
                    r_count   <= CW'(WIDTH - 1);
                    r_state   <= ITER;
                end
                ITER: begin
                    if (!r_op[2]) begin
                        r_acc   <= w_acc_next;
                        r_mcand <= r_mcand << 1;
                        r_y     <= r_y >> 1;
                    end else if (w_ge) begin
                        r_rem <= w_sub;
                        r_x   <= {r_x[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_x   <= {r_x[WIDTH-2:0], 1'b0};
                    end
                    if (r_count == '0) begin
                        r_state <= FIXUP;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                FIXUP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/otter_alu_md.sv
// OTTER execute unit: single-cycle base ALU plus iterative RV32M engine,
// sharing one registered RESULT/OUT_VALID output.
module otter_alu_md
    import otter_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    localparam int SHW = $clog2(WIDTH);

    logic             w_accept, w_md_busy, w_md_done;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu, w_md_result;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;

    otter_md_core #(.WIDTH(WIDTH)) u_md_core (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_start  (w_accept & OP[4]),
        .i_funct3 (OP[2:0]),
        .i_a      (SRC_A),
        .i_b      (SRC_B),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // Base ALU; unknown codes produce zero
    always_comb begin
        w_shamt = SRC_B[SHW-1:0];
        w_alu   = '0;
        case (OP[3:0])
            ALU_ADD:  w_alu = SRC_A + SRC_B;
            ALU_SUB:  w_alu = SRC_A - SRC_B;
            ALU_OR:   w_alu = SRC_A | SRC_B;
            ALU_AND:  w_alu = SRC_A & SRC_B;
            ALU_XOR:  w_alu = SRC_A ^ SRC_B;
            ALU_SRL:  w_alu = SRC_A >> w_shamt;
            ALU_SLL:  w_alu = SRC_A << w_shamt;
            ALU_SRA:  w_alu = $signed(SRC_A) >>> w_shamt;
            ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(SRC_A) < $signed(SRC_B))};
            ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (SRC_A < SRC_B)};
            ALU_LUI:  w_alu = SRC_A;
            default:  w_alu = '0;
        endcase
    end

    // Output register: M-op completion or base-op accept produces a one-cycle valid pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_md_done) begin
            r_result    <= w_md_result;
            r_out_valid <= 1'b1;
        end else if (w_accept && !OP[4]) begin
            r_result    <= w_alu;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign IN_READY  = ~w_md_busy;
    assign w_accept  = IN_VALID & IN_READY;
    assign OUT_VALID = r_out_valid;
    assign RESULT    = r_result;
    assign ZERO      = (r_result == '0);

endmodule

// File: tb/tb_otter_alu_md.sv
// Self-checking bench for otter_alu_md: directed cases, randomized ops against a
// plain-arithmetic reference model, reset/abort, back-to-back and an 8-bit build.
module tb_otter_alu_md;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [4:0]  OP = '0;
    logic [31:0] SRC_A = '0;
    logic [31:0] SRC_B = '0;
    logic        OUT_VALID;
    logic [31:0] RESULT;
    logic        ZERO;

    logic        IN_VALID8 = 1'b0;
    logic        IN_READY8;
    logic [4:0]  OP8 = '0;
    logic [7:0]  SRC_A8 = '0;
    logic [7:0]  SRC_B8 = '0;
    logic        OUT_VALID8;
    logic [7:0]  RESULT8;
    logic        ZERO8;

    int checks = 0;
    int errors = 0;

    otter_alu_md #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .OUT_VALID(OUT_VALID), .RESULT(RESULT), .ZERO(ZERO)
    );

    otter_alu_md #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID8), .IN_READY(IN_READY8), .OP(OP8),
        .SRC_A(SRC_A8), .SRC_B(SRC_B8), .OUT_VALID(OUT_VALID8), .RESULT(RESULT8), .ZERO(ZERO8)
    );

    always #5 CLK = ~CLK;

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic on the RV32 definitions
    function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        int          ia, ib;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        sh = b[4:0];
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0110: return a | b;
                4'b0111: return a & b;
                4'b0100: return a ^ b;
                4'b0101: return a >> sh;
                4'b0001: return a << sh;
                4'b1101: return 32'($signed(a) >>> sh);
                4'b0010: return (ia < ib) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                4'b1001: return a;
                default: return 32'd0;
            endcase
        end
        case (op[2:0])
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present an op, wait (bounded) for ready and return one step after the accept edge
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        OP = op; SRC_A = a; SRC_B = b; IN_VALID = 1'b1;
        while (IN_READY !== 1'b1 && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 100) checkOutput("ready_timeout", {31'b0, IN_READY}, 32'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    // Count edges after accept until OUT_VALID, then check latency and result
    task automatic waitResult(input string tag, input int expLat, input logic [31:0] expRes);
        int lat;
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < 200) begin
            @(posedge CLK); #1; lat++;
        end
        checkOutput({tag, "_lat"}, lat, expLat);
        checkOutput({tag, "_res"}, RESULT, expRes);
        checkOutput({tag, "_zero"}, {31'b0, ZERO}, {31'b0, expRes == 32'd0});
    endtask

    task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(op, a, b);
        waitResult(tag, op[4] ? 34 : 0, refModel(op, a, b));
    endtask

    task automatic runDirected(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
        applyStimulus(op, a, b);
        waitResult(tag, op[4] ? 34 : 0, exp);
    endtask

    // 8-bit build: same handshake, latency WIDTH+2 = 10 for M ops
    task automatic run8(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp);
        int n;
        n = 0;
        OP8 = op; SRC_A8 = a; SRC_B8 = b; IN_VALID8 = 1'b1;
        while (IN_READY8 !== 1'b1 && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        @(posedge CLK); #1;
        IN_VALID8 = 1'b0;
        n = 0;
        while (OUT_VALID8 !== 1'b1 && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        checkOutput({tag, "_lat"}, n, op[4] ? 32'd10 : 32'd0);
        checkOutput({tag, "_res"}, {24'b0, RESULT8}, {24'b0, exp});
    endtask

    initial begin
        int lat, pulses;
        logic busyOk;
        logic [4:0] op;
        logic [31:0] a, b;

        // Reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("rst_ready", {31'b0, IN_READY}, 32'd1);
        checkOutput("rst_valid", {31'b0, OUT_VALID}, 32'd0);
        checkOutput("rst_result", RESULT, 32'd0);
        checkOutput("rst_zero", {31'b0, ZERO}, 32'd1);

        // Base ops
        runDirected("add_wrap", 5'b00000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        runDirected("sra_mask", 5'b01101, 32'h8000_0000, 32'h24, 32'hF800_0000);
        runDirected("sltu", 5'b00011, 32'd1, 32'hFFFF_FFFF, 32'd1);
        runDirected("sub_zero", 5'b01000, 32'd5, 32'd5, 32'd0);
        runDirected("bad_code", 5'b01111, 32'h1234, 32'h5678, 32'd0);

        // M op latency with ignored IN_VALID pulses while busy
        applyStimulus(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 0;
        busyOk = 1'b1;
        while (OUT_VALID !== 1'b1 && lat < 200) begin
            IN_VALID = (lat % 5 == 0);
            OP = 5'b00000; SRC_A = 32'd3; SRC_B = 32'd4;
            if (IN_READY !== 1'b0) busyOk = 1'b0;
            @(posedge CLK); #1; lat++;
        end
        IN_VALID = 1'b0;
        checkOutput("mulhu_lat", lat, 32'd34);
        checkOutput("mulhu_res", RESULT, 32'hFFFF_FFFE);
        checkOutput("mulhu_busy", {31'b0, busyOk}, 32'd1);
        @(posedge CLK); #1;
        checkOutput("mulhu_nodup", {31'b0, OUT_VALID}, 32'd0);

        // Signed mul/div and special cases
        runDirected("mulh", 5'b10001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        runDirected("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        runDirected("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runDirected("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runDirected("divu_by0", 5'b10101, 32'd9, 32'd0, 32'hFFFF_FFFF);
        runDirected("rem_by0", 5'b10110, 32'd9, 32'd0, 32'd9);
        runDirected("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runDirected("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Back-to-back: base op accepted in the OUT_VALID cycle of a div
        runDirected("b2b_div", 5'b10101, 32'd100, 32'd7, 32'd14);
        checkOutput("b2b_ready", {31'b0, IN_READY}, 32'd1);
        applyStimulus(5'b00110, 32'hF0, 32'h0F);
        checkOutput("b2b_valid", {31'b0, OUT_VALID}, 32'd1);
        checkOutput("b2b_res", RESULT, 32'hFF);

        // Abort in ITER cycle 10
        applyStimulus(5'b10100, 32'd1000, 32'd7);
        repeat (10) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("abort_valid", {31'b0, OUT_VALID}, 32'd0);
        checkOutput("abort_ready", {31'b0, IN_READY}, 32'd1);
        checkOutput("abort_result", RESULT, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (OUT_VALID === 1'b1) pulses++;
        end
        checkOutput("abort_quiet", pulses, 32'd0);

        // Reset together with IN_VALID: op must not be accepted
        OP = 5'b10101; SRC_A = 32'd50; SRC_B = 32'd3; IN_VALID = 1'b1; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; IN_VALID = 1'b0;
        checkOutput("rstvalid_ready", {31'b0, IN_READY}, 32'd1);
        pulses = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (OUT_VALID === 1'b1) pulses++;
        end
        checkOutput("rstvalid_quiet", pulses, 32'd0);

        // Randomized mix against the reference model
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                op = {1'b0, 4'($urandom_range(0, 15))};
                if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            end else begin
                op = {2'b10, 3'($urandom_range(0, 7))};
                case ($urandom_range(0, 7))
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = $urandom_range(1, 300);
                    3: a = $urandom_range(0, 1000);
                    default: ;
                endcase
            end
            runOp($sformatf("rand%0d_op%0h", i, op), op, a, b);
        end

        // WIDTH=8 build
        run8("w8_divu", 5'b10101, 8'd200, 8'd7, 8'd28);
        run8("w8_remu", 5'b10111, 8'd200, 8'd7, 8'd4);
        run8("w8_mul", 5'b10000, 8'd16, 8'd16, 8'h00);
        run8("w8_sra", 5'b01101, 8'h80, 8'h0C, 8'hF8);
        run8("w8_div_neg", 5'b10100, 8'hF9, 8'd2, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
